// File: rtl/nn_act_pingpong_buffer_pkg.sv
// rtl/nn_act_pingpong_buffer_pkg.sv - shared types and constants for the activation ping-pong buffer
package nn_act_pingpong_buffer_pkg;
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_e;

  localparam int DATA_W        = 8;
  localparam int ERR_UNDERFLOW = 0;
  localparam int ERR_BAD_ADDR  = 1;
endpackage

// File: rtl/nn_act_bank.sv
// rtl/nn_act_bank.sv - one N x W activation register bank, parallel load, async indexed read
module nn_act_bank #(
  parameter int N  = 2,
  parameter int W  = 8,
  parameter int AW = 1
) (
  input  logic           clk,
  input  logic           we_i,
  input  logic [N*W-1:0] wdata_i,
  input  logic [AW-1:0]  idx_i,
  output logic [W-1:0]   rdata_o
);
  localparam logic [AW:0] N_L = (AW+1)'(N);

  logic [W-1:0] mem_q [N];

  // Contents are deliberately left unreset; readers gate on bank state.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= wdata_i[i*W +: W];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    if ({1'b0, idx_i} < N_L) rdata_o = mem_q[idx_i];
  end
endmodule

// File: rtl/nn_act_pingpong_buffer.sv
// rtl/nn_act_pingpong_buffer.sv - two-bank activation vector buffer with element-wise read port
module nn_act_pingpong_buffer
  import nn_act_pingpong_buffer_pkg::*;
#(
  parameter int N  = 2,
  parameter int W  = DATA_W,
  parameter int AW = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [N*W-1:0] wr_data,
  output logic           rd_req,
  input  logic           rd_trig,
  input  logic [AW-1:0]  rd_addr,
  output logic [W-1:0]   rd_data,
  input  logic           rd_release,
  output logic [1:0]     occupancy,
  output logic [1:0]     err
);
  localparam logic [AW:0] N_L = (AW+1)'(N);

  bank_state_e state_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  err_q;
  logic [1:0]  err_d;

  logic        wr_fire;
  logic        rel_fire;
  logic        addr_ok;
  logic [1:0]  bank_we;
  logic [W-1:0] bank_rd [2];

  assign wr_ready = (state_q[wr_ptr_q] == EMPTY);
  assign rd_req   = (state_q[rd_ptr_q] == FULL);
  assign wr_fire  = wr_valid & wr_ready;
  assign rel_fire = rd_release & rd_req;
  assign addr_ok  = ({1'b0, rd_addr} < N_L);

  always_comb begin
    err_d = err_q;
    if (rd_trig && !addr_ok) err_d[ERR_BAD_ADDR] = 1'b1;
    if (rd_release && !rd_req) err_d[ERR_UNDERFLOW] = 1'b1;
  end

  // A write needs an EMPTY bank and a release a FULL one, so both may fire on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      err_q      <= 2'b00;
    end else begin
      if (wr_fire) begin
        state_q[wr_ptr_q] <= FULL;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (rel_fire) begin
        state_q[rd_ptr_q] <= EMPTY;
        rd_ptr_q          <= ~rd_ptr_q;
      end
      err_q <= err_d;
    end
  end

  assign bank_we[0] = wr_fire & ~wr_ptr_q;
  assign bank_we[1] = wr_fire &  wr_ptr_q;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    nn_act_bank #(.N(N), .W(W), .AW(AW)) u_bank (
      .clk     (clk),
      .we_i    (bank_we[b]),
      .wdata_i (wr_data),
      .idx_i   (rd_addr),
      .rdata_o (bank_rd[b])
    );
  end

  assign rd_data   = (rd_req && addr_ok) ? bank_rd[rd_ptr_q] : '0;
  assign occupancy = {1'b0, state_q[0] == FULL} + {1'b0, state_q[1] == FULL};
  assign err       = err_q;
endmodule

// File: tb/tb_nn_act_pingpong_buffer.sv
// tb/tb_nn_act_pingpong_buffer.sv - randomized bench with a behavioural reference model
module tb_nn_act_pingpong_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic        rd_req;
  logic        rd_trig = 1'b0;
  logic [0:0]  rd_addr = '0;
  logic [7:0]  rd_data;
  logic        rd_release = 1'b0;
  logic [1:0]  occupancy;
  logic [1:0]  err;

  logic        rst3 = 1'b1;
  logic        wr_valid3 = 1'b0;
  logic        wr_ready3;
  logic [23:0] wr_data3 = '0;
  logic        rd_req3;
  logic        rd_trig3 = 1'b0;
  logic [1:0]  rd_addr3 = '0;
  logic [7:0]  rd_data3;
  logic        rd_release3 = 1'b0;
  logic [1:0]  occupancy3;
  logic [1:0]  err3;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  nn_act_pingpong_buffer u_dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_req(rd_req), .rd_trig(rd_trig), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_release(rd_release), .occupancy(occupancy), .err(err)
  );

  nn_act_pingpong_buffer #(.N(3), .W(8), .AW(2)) u_dut3 (
    .clk(clk), .rst(rst3), .wr_valid(wr_valid3), .wr_ready(wr_ready3), .wr_data(wr_data3),
    .rd_req(rd_req3), .rd_trig(rd_trig3), .rd_addr(rd_addr3), .rd_data(rd_data3),
    .rd_release(rd_release3), .occupancy(occupancy3), .err(err3)
  );

  // Reference model: a queue of full vectors (oldest is the one being read) plus a bank count.
  logic [15:0] m_q[$];
  logic [1:0]  m_err = 2'b00;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_err = 2'b00;
    end else begin
      bit do_wr, do_rel;
      do_wr = wr_valid && (m_q.size() < 2);
      do_rel = rd_release && (m_q.size() > 0);
      if (rd_release && m_q.size() == 0) m_err[0] = 1'b1;
      if (do_rel) void'(m_q.pop_front());
      if (do_wr) m_q.push_back(wr_data);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int exp_rd_data();
    logic [15:0] v;
    if (m_q.size() == 0) return 0;
    v = m_q[0];
    return int'(rd_addr[0] ? v[15:8] : v[7:0]);
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("wr_ready", int'(wr_ready), int'(m_q.size() < 2));
      chk("rd_req", int'(rd_req), int'(m_q.size() > 0));
      chk("occupancy", int'(occupancy), m_q.size());
      chk("rd_data", int'(rd_data), exp_rd_data());
      chk("err", int'(err), int'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_wr_ready", int'(wr_ready), 1);
    chk("reset_rd_req", int'(rd_req), 0);
    chk("reset_occupancy", int'(occupancy), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    chk("reset_err", int'(err), 0);

    // e1=33, e0=-58
    wr_valid = 1'b1; wr_data = {8'd33, 8'hC6};
    tick();
    wr_valid = 1'b0; rd_trig = 1'b1; rd_addr = 1'b0;
    @(negedge clk);
    chk("w1_rd_req", int'(rd_req), 1);
    chk("w1_occupancy", int'(occupancy), 1);
    chk("w1_addr0", int'(rd_data), 8'hC6);
    #1 rd_addr = 1'b1;
    #1 chk("w1_addr1", int'(rd_data), 8'h21);

    tick();
    rd_trig = 1'b0;
    wr_valid = 1'b1; wr_data = {8'd100, 8'd200};
    tick();
    wr_data = {8'd7, 8'd7};
    @(negedge clk);
    chk("full_occupancy", int'(occupancy), 2);
    chk("full_wr_ready", int'(wr_ready), 0);
    tick();
    wr_valid = 1'b0; rd_addr = 1'b0;
    @(negedge clk);
    chk("ignored_occupancy", int'(occupancy), 2);
    chk("ignored_addr0", int'(rd_data), 8'hC6);
    #1 rd_addr = 1'b1;
    #1 chk("ignored_addr1", int'(rd_data), 8'h21);

    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
    @(negedge clk);
    chk("rel_occupancy", int'(occupancy), 1);
    tick();
    // write {5,-3} together with release of the other bank
    wr_valid = 1'b1; wr_data = {8'd5, 8'hFD}; rd_release = 1'b1;
    tick();
    wr_valid = 1'b0; rd_release = 1'b0; rd_addr = 1'b0;
    @(negedge clk);
    chk("simul_occupancy", int'(occupancy), 1);
    chk("simul_addr0", int'(rd_data), 8'hFD);
    #1 rd_addr = 1'b1;
    #1 chk("simul_addr1", int'(rd_data), 8'h05);

    rd_release = 1'b1;
    tick();
    @(negedge clk);
    chk("empty_rd_req", int'(rd_req), 0);
    tick();
    rd_release = 1'b0;
    @(negedge clk);
    chk("underflow_err", int'(err), 2'b01);
    chk("underflow_occupancy", int'(occupancy), 0);

    wr_valid = 1'b1; wr_data = 16'h1234;
    tick(); tick();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("prereset_occupancy", int'(occupancy), 2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_occupancy", int'(occupancy), 0);
    chk("midreset_rd_req", int'(rd_req), 0);
    chk("midreset_wr_ready", int'(wr_ready), 1);
    chk("midreset_err", int'(err), 0);

    for (int c = 0; c < 600; c++) begin
      tick();
      rst        = ($urandom_range(0, 79) == 0);
      wr_valid   = $urandom_range(0, 1);
      wr_data    = 16'($urandom);
      rd_trig    = $urandom_range(0, 1);
      rd_addr    = 1'($urandom_range(0, 1));
      rd_release = ($urandom_range(0, 2) == 0);
    end
    tick();
    rst = 1'b0; wr_valid = 1'b0; rd_release = 1'b0; rd_trig = 1'b0;

    // N=3, AW=2 instance: address 3 is out of range
    rst3 = 1'b0;
    wr_valid3 = 1'b1; wr_data3 = 24'h11_22_33;
    tick();
    wr_valid3 = 1'b0; rd_trig3 = 1'b1; rd_addr3 = 2'd2;
    @(negedge clk);
    chk("n3_addr2", int'(rd_data3), 8'h11);
    chk("n3_err_clean", int'(err3), 0);
    #1 rd_addr3 = 2'd3;
    #1 chk("n3_addr3_data", int'(rd_data3), 0);
    tick();
    rd_trig3 = 1'b0; rd_addr3 = 2'd0;
    @(negedge clk);
    chk("n3_bad_addr_err", int'(err3), 2'b10);
    chk("n3_addr0", int'(rd_data3), 8'h33);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
